control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Moore-FSM control unit for the 32-bit, 16-register CPU datapath. Sequences fetch (T0-T2)
//  and per-opcode execute steps (T3-T7). Drives register-select/encode strobes (Gra/Grb/Grc,
//  Rin/Rout/BAout), bus-source/sink enables, memory Read/Write and ALU op. Consumes the
//  5-bit opcode decoded from IR[31:27]. One state per clock; outputs depend only on state.
// PARAMETERS
//  NOP_OPCODE   5'b11010  opcode executed as no-op
//  HALT_OPCODE  5'b11011  opcode that parks FSM in HALT until reset
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high; forces RESET_ST
//  opcode    in   5  IR[31:27], valid from T3 onward
//  stop      in   1  pause request, sampled on T0 entry
//  mem_ready in   1  memory handshake (port exists only with MEM_WAIT_EN)
//  PCout,PCin,IncPC,MARin,MDRin,MDRout,IRin,Yin,Zin,Zlowout,Cout  out 1 each  datapath enables
//  Read,Write    out 1  memory strobes
//  Gra,Grb,Grc   out 1  register-field selects
//  Rin,Rout,BAout out 1 register-file in/out/base-address-out strobes
//  alu_op    out  5  ALU function (opcode encoding of add/sub/and/...)
//  run       out  1  1 in any state except RESET_ST/HALT/PAUSE
//  instr_done out 1  1-cycle pulse in last execute state of each instruction
//  illegal   out  1  sticky; set on unassigned opcode, cleared only by reset
// BEHAVIOUR
//  - Reset: state=RESET_ST, every output 0, illegal=0. First edge after release -> T0.
//  - Any output not listed for a state is 0. alu_op=0 except where listed.
//  - T0: PCout MARin IncPC Zin.  T1: Zlowout PCin Read MDRin.  T2: MDRout IRin.
//  - 3-reg ALU 00011-01011: T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=opcode; T5 Zlowout Gra Rin.
//  - Imm ALU 01100/01101/01110: T3 Grb Rout Yin; T4 Cout Zin alu_op=00011/00101/00110;
//    T5 Zlowout Gra Rin.
//  - ldi 00001: T3 Grb BAout Yin; T4 Cout Zin alu_op=00011; T5 Zlowout Gra Rin.
//  - ld 00000: T3-T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
//  - st 00010: T3-T5 as ld; T6 Gra Rout MDRin; T7 Write.
//  - NOP_OPCODE: T3 only (no enables), instr_done=1, -> T0.
//  - HALT_OPCODE: T3 -> HALT; run=0; only reset exits.
//  - Unassigned (01111-11001, 111xx): behaves as NOP; illegal set on the T3 edge.
//  - instr_done asserted in T5 (ALU/imm/ldi), T7 (ld/st), T3 (nop/illegal).
//  - stop: if stop=1 on the edge leaving a last execute state, go PAUSE (run=0, outputs 0);
//    PAUSE -> T0 on first edge with stop=0. Mid-instruction stop has no effect.
//  - Gra/Grb/Grc are never asserted together; Rin and Rout are never asserted together.
//  - Reset mid-instruction: immediate return to RESET_ST, all strobes drop asynchronously.
// CONFIGURATION
//  MEM_WAIT_EN defined: mem_ready port present. T1, ld-T6, st-T7 hold state with outputs
//    held while mem_ready=0; advance on first edge with mem_ready=1. instr_done in ld/st T7
//    asserts only on the completing cycle.
//  MEM_WAIT_EN undefined: no mem_ready port; every access state lasts exactly 1 cycle.
// TESTING
//  1 reset pulse mid-T4 -> all outputs 0 same cycle; T0 one edge after release, run=1.
//  2 opcode=00011 (add) -> T0..T5 = 6 cycles; T4 alu_op=00011, Grc Rout Zin; T5 Gra Rin, done=1.
//  3 opcode=00000 (ld) -> 8 cycles; T6 Read MDRin; T7 MDRout Gra Rin instr_done=1.
//  4 stop=1 during st T7 -> PAUSE, run=0; stop=0 -> T0 next edge. opcode=11011 -> HALT, run=0.
//  5 opcode=10000 -> T3 instr_done=1, illegal=1 and stays 1 through next add instruction.
//  6 MEM_WAIT_EN, mem_ready=0 for 3 cycles in T1 -> Read/MDRin held 4 cycles, then T2.

Source files
------------

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) and per-opcode execute steps (T3-T7) for the 32-bit CPU.
// Define MEM_WAIT_EN to add the mem_ready port and stretch T1 / ld-T6 / st-T7 until memory is ready.
module control_sequencer #(
    parameter logic [4:0] NOP_OPCODE  = 5'b11010,
    parameter logic [4:0] HALT_OPCODE = 5'b11011
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] opcode,
    input  logic       stop,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       Cout,
    output logic       Read,
    output logic       Write,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic [4:0] alu_op,
    output logic       run,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7, HALT, PAUSE
    } state_t;

    state_t state, next_state;
    logic   mem_ok;
    logic   last;
    logic   is_ld, is_ldi, is_st, is_alu3, is_imm, is_nop, is_halt, is_bad;
    logic   is_mem, is_ba;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        is_ld   = (opcode == 5'b00000);
        is_ldi  = (opcode == 5'b00001);
        is_st   = (opcode == 5'b00010);
        is_alu3 = (opcode >= 5'b00011) && (opcode <= 5'b01011);
        is_imm  = (opcode >= 5'b01100) && (opcode <= 5'b01110);
        is_nop  = (opcode == NOP_OPCODE);
        is_halt = (opcode == HALT_OPCODE);
        is_bad  = !(is_ld || is_ldi || is_st || is_alu3 || is_imm || is_nop || is_halt);
        is_mem  = is_ld || is_st;
        is_ba   = is_ld || is_ldi || is_st;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RESET_ST;
        else       state <= next_state;
    end

    // Sticky: an unassigned opcode is latched as it leaves T3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        illegal <= 1'b0;
        else if (state == T3 && is_bad)   illegal <= 1'b1;
    end

    assign run       = !(state == RESET_ST || state == HALT || state == PAUSE);
    assign state_dbg = state;

    always_comb begin
        next_state = state;
        last       = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        Cout = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_op     = 5'b00000;
        instr_done = 1'b0;
        case (state)
            RESET_ST: next_state = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                next_state = T1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_ok) next_state = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                if (is_halt) begin
                    next_state = HALT;
                end else if (is_nop || is_bad) begin
                    instr_done = 1'b1;
                    last       = 1'b1;
                end else begin
                    Grb   = 1'b1;
                    Yin   = 1'b1;
                    BAout = is_ba;
                    Rout  = !is_ba;
                    next_state = T4;
                end
            end
            T4: begin
                Zin = 1'b1;
                if (is_alu3) begin
                    Grc = 1'b1; Rout = 1'b1;
                    alu_op = opcode;
                end else begin
                    Cout = 1'b1;
                    // Immediate forms map onto addi/andi/ori ALU codes; address forms add.
                    case (opcode)
                        5'b01101: alu_op = 5'b00101;
                        5'b01110: alu_op = 5'b00110;
                        default:  alu_op = 5'b00011;
                    endcase
                end
                next_state = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_mem) begin
                    MARin = 1'b1;
                    next_state = T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    instr_done = 1'b1;
                    last       = 1'b1;
                end
            end
            T6: begin
                MDRin = 1'b1;
                if (is_ld) begin
                    Read = 1'b1;
                    if (mem_ok) next_state = T7;
                end else begin
                    Gra = 1'b1; Rout = 1'b1;
                    next_state = T7;
                end
            end
            T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    instr_done = 1'b1;
                    last       = 1'b1;
                end else begin
                    Write = 1'b1;
                    if (mem_ok) begin
                        instr_done = 1'b1;
                        last       = 1'b1;
                    end
                end
            end
            HALT:  next_state = HALT;
            PAUSE: if (!stop) next_state = T0;
            default: next_state = RESET_ST;
        endcase
        if (last) next_state = stop ? PAUSE : T0;
    end

endmodule
